// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divider: opcode encodings, FSM states and
// small two's-complement helpers used by the datapath.
package div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [1:0] OP_DIV  = F3_DIV[1:0];
    localparam logic [1:0] OP_DIVU = F3_DIVU[1:0];
    localparam logic [1:0] OP_REM  = F3_REM[1:0];
    localparam logic [1:0] OP_REMU = F3_REMU[1:0];

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    function automatic logic opIsSigned(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic opIsRem(input logic [1:0] op);
        return !((op == OP_DIVU) || (op == OP_DIV));
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import div_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic            quo_msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] next_rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] shifted;

    // The shifted remainder is XLEN+1 bits because a divisor above 2^(XLEN-1)
    // lets the partial remainder use its top bit; the result always fits XLEN.
    always_comb begin
        shifted    = {rem_i, quo_msb_i};
        q_bit_o    = (shifted >= {1'b0, divisor_i});
        next_rem_o = shifted[XLEN-1:0] - (q_bit_o ? divisor_i : '0);
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): restoring division on operand
// magnitudes followed by a sign fix-up; zero divisor and overflow finish early.
module div_unit
    import div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    div_state_e       state_q;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  div_q;
    logic [1:0]       op_q;
    logic             negQuo_q;
    logic             negRem_q;
    logic [XLEN-1:0]  result_q;
    logic             out_valid_q;

    logic             signedOp;
    logic             divByZero;
    logic             overflow;
    logic [XLEN-1:0]  dividendMag;
    logic [XLEN-1:0]  divisorMag;
    logic [XLEN-1:0]  specialResult;
    logic [XLEN-1:0]  rem_d;
    logic             qBit;
    logic [XLEN-1:0]  fixResult;

    div_step u_step (
        .rem_i      (rem_q),
        .quo_msb_i  (quo_q[XLEN-1]),
        .divisor_i  (div_q),
        .next_rem_o (rem_d),
        .q_bit_o    (qBit)
    );

    // Request decode: magnitudes only for signed ops, early-out results for
    // the two cases that never need the iterative datapath.
    always_comb begin
        signedOp    = opIsSigned(op);
        divByZero   = (rs2 == '0);
        overflow    = signedOp && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        dividendMag = (signedOp && rs1[XLEN-1]) ? negate(rs1) : rs1;
        divisorMag  = (signedOp && rs2[XLEN-1]) ? negate(rs2) : rs2;
        if (divByZero) begin
            specialResult = opIsRem(op) ? rs1 : '1;
        end else begin
            specialResult = opIsRem(op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
        if (opIsRem(op_q)) begin
            fixResult = negRem_q ? negate(rem_q) : rem_q;
        end else begin
            fixResult = negQuo_q ? negate(quo_q) : quo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            op_q        <= '0;
            negQuo_q    <= 1'b0;
            negRem_q    <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    out_valid_q <= 1'b0;
                    if (in_valid) begin
                        op_q     <= op;
                        negQuo_q <= signedOp && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                        negRem_q <= signedOp && rs1[XLEN-1];
                        rem_q    <= '0;
                        quo_q    <= dividendMag;
                        div_q    <= divisorMag;
                        count_q  <= '0;
                        if (divByZero || overflow) begin
                            result_q    <= specialResult;
                            out_valid_q <= 1'b1;
                            state_q     <= DIV_DONE;
                        end else begin
                            state_q <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    if (flush) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q   <= rem_d;
                        quo_q   <= {quo_q[XLEN-2:0], qBit};
                        count_q <= count_q + CNT_W'(1);
                        if (count_q == CNT_W'(XLEN - 1)) begin
                            state_q <= DIV_FIX;
                        end
                    end
                end
                DIV_FIX: begin
                    if (flush) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        result_q    <= fixResult;
                        out_valid_q <= 1'b1;
                        state_q     <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    out_valid_q <= 1'b0;
                    state_q     <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == DIV_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, flush and reset
// aborts, then randomized back-to-back traffic against an arithmetic model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        out_valid;
    logic [31:0] result;

    int checkCount = 0;
    int failCount  = 0;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // RISC-V M-extension division semantics written directly from the ISA rules.
    function automatic logic [31:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic isRem;
        logic isSigned;
        logic [31:0] r;
        isRem    = o[1];
        isSigned = !o[0];
        if (b == 32'd0) begin
            r = isRem ? a : 32'hFFFF_FFFF;
        end else if (isSigned && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = isRem ? 32'd0 : 32'h8000_0000;
        end else if (isSigned) begin
            r = isRem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        end else begin
            r = isRem ? a % b : a / b;
        end
        return r;
    endfunction

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd1;
            4: v = $urandom_range(0, 20);
            5: v = -$urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Presents one request in an idle cycle; after the accept edge the
    // operand buses are scrambled so any re-sampling would corrupt the result.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        op       = opIn;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 2'($urandom);
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    task automatic runAndCheck(input string tag, input logic [1:0] opIn, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected, input logic early);
        int lat;
        applyStimulus(opIn, a, b);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), early ? 32'd0 : 32'd33);
        checkOutput({tag, "_result"}, result, expected);
        @(posedge clk);
        #1;
        checkOutput({tag, "_readyBack"}, {31'd0, in_ready}, 32'd1);
        checkOutput({tag, "_pulseEnd"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] prevResult;
        logic        seen;
        logic [31:0] expQ[$];
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        int          cycles;
        int          done;

        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        rs1      = '0;
        rs2      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetReady", {31'd0, in_ready}, 32'd1);
        checkOutput("resetValid", {31'd0, out_valid}, 32'd0);
        checkOutput("resetResult", result, 32'd0);
        rst = 1'b0;

        runAndCheck("divu100_7", DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
        runAndCheck("remu100_7", REMU, 32'd100, 32'd7, 32'd2, 1'b0);
        runAndCheck("divNeg7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        runAndCheck("remNeg7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        runAndCheck("rem7_neg2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        runAndCheck("divOverflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        runAndCheck("remOverflow", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        runAndCheck("divByZero", DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1);
        runAndCheck("remuByZero", REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1);

        // Abort a division partway through the iterations.
        prevResult = 32'h1234_5678;
        applyStimulus(DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flushValid", {31'd0, out_valid}, 32'd0);
        checkOutput("flushReady", {31'd0, in_ready}, 32'd1);
        checkOutput("flushResult", result, prevResult);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checkOutput("flushNoPulse", {31'd0, seen}, 32'd0);
        runAndCheck("divu9_3", DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

        // Asynchronous reset in the middle of the iterations.
        applyStimulus(DIV, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstReady", {31'd0, in_ready}, 32'd1);
        checkOutput("asyncRstValid", {31'd0, out_valid}, 32'd0);
        checkOutput("asyncRstResult", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checkOutput("asyncRstNoPulse", {31'd0, seen}, 32'd0);

        // Back-to-back random traffic with in_valid held high throughout.
        cycles = 0;
        done   = 0;
        @(negedge clk);
        in_valid = 1'b1;
        while (done < 1000 && cycles < 50000) begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("randUnexpectedValid", 32'd1, 32'd0);
                end else begin
                    checkOutput("randResult", result, expQ.pop_front());
                    done++;
                end
            end
            o   = 2'($urandom_range(0, 3));
            a   = pickOperand();
            b   = pickOperand();
            op  = o;
            rs1 = a;
            rs2 = b;
            if (in_ready) begin
                checkOutput("randOneOutstanding", 32'(expQ.size()), 32'd0);
                expQ.push_back(refModel(o, a, b));
            end
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        checkOutput("randCompleted", 32'(done), 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
